// File: rtl/sd_card_data_responder.sv
// sd_card_data_responder
//   Card side of the SD DAT0 data line. A host write is received as a framed
//   block: start bit, data MSB first, CRC16, end bit. The card then answers
//   with the CRC status token and holds busy. A host read sends one framed
//   block built from words fetched out of a card-side buffer.
//
//   Optional feature macro: SD_CARD_CRC_EN
//     defined   - CRC16 (x^16+x^12+x^5+1, init 0) is computed on the data bits
//                 of both received and transmitted blocks.
//     undefined - the received CRC field is consumed but ignored, and the
//                 transmitted CRC field is sent as 16'h0000.
//
// Ports
//   iClock             SD clock; every register updates on the rising edge
//   iReset             asynchronous reset, active low
//   iData_pin          DAT0 as driven by the host
//   oData_pin          DAT0 value driven by the card
//   oData_oe           card drives DAT0 while 1
//   iWrite_start       pulse: arm reception of one block
//   iRead_start        pulse: transmit one block
//   iAbort             synchronous return to IDLE; releases DAT0
//   iData_from_buffer  next word to send, valid one cycle after oRead_enable
//   oRead_enable       one-cycle request for the next word
//   oData_to_buffer    received word
//   oWrite_enable      one-cycle strobe; oData_to_buffer is valid
//   oBlock_done        one-cycle pulse at the end of write busy or after the read end bit
//   oCrc_error         sticky error flag for the last received block
module sd_card_data_responder #(
   parameter int WORD_SIZE       = 32,
   parameter int WORDS_PER_BLOCK = 16,
   parameter int NAC             = 2,
   parameter int BUSY_CYCLES     = 8
) (
   input  logic                 iClock,
   input  logic                 iReset,
   input  logic                 iData_pin,
   output logic                 oData_pin,
   output logic                 oData_oe,
   input  logic                 iWrite_start,
   input  logic                 iRead_start,
   input  logic                 iAbort,
   input  logic [WORD_SIZE-1:0] iData_from_buffer,
   output logic                 oRead_enable,
   output logic [WORD_SIZE-1:0] oData_to_buffer,
   output logic                 oWrite_enable,
   output logic                 oBlock_done,
   output logic                 oCrc_error
);

   localparam int BLOCK_BITS = WORD_SIZE * WORDS_PER_BLOCK;
   localparam int BIT_W      = $clog2(BLOCK_BITS + 1);
   localparam int WBIT_W     = $clog2(WORD_SIZE);
   localparam int WORD_W     = $clog2(WORDS_PER_BLOCK + 1);
   localparam int PH_MAX_A   = (NAC > 16) ? NAC : 16;
   localparam int PH_MAX     = (BUSY_CYCLES + 1 > PH_MAX_A) ? BUSY_CYCLES + 1 : PH_MAX_A;
   localparam int PH_W       = $clog2(PH_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, RX_WAIT, RX_DATA, RX_CRC, RX_END, TOK_GAP, TOK, BUSY,
      TX_WAIT, TX_DATA, TX_CRC, TX_END
   } state_t;

   state_t               state_q, state_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;   // data bits of the block so far
   logic [WBIT_W-1:0]    wbit_q, wbit_d;         // bit position inside current word
   logic [WORD_W-1:0]    word_q, word_d;         // word index inside block
   logic [PH_W-1:0]      ph_q, ph_d;             // cycle counter for wait/CRC/token/busy
   logic [WORD_SIZE-1:0] sr_q, sr_d;             // RX/TX shift register
   logic                 ld_q, ld_d;             // buffer word arrives this cycle
   logic                 we_q, we_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;
   logic                 done_q, done_d;
   logic                 crc_err_q, crc_err_d;

   logic        pin_c, oe_c, rd_en_c;
   logic        crc_clr, crc_in_valid, crc_in_bit, crc_tx_shift, rx_crc_shift;
   logic [15:0] crc_val;
   logic        crc_match;

`ifdef SD_CARD_CRC_EN
   logic [15:0] crc_q, rx_crc_q;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         crc_q    <= 16'h0000;
         rx_crc_q <= 16'h0000;
      end else begin
         if (crc_clr)
            crc_q <= 16'h0000;
         else if (crc_in_valid)
            crc_q <= {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ crc_in_bit) ? 16'h1021 : 16'h0000);
         else if (crc_tx_shift)
            crc_q <= {crc_q[14:0], 1'b0};   // CRC field goes out MSB first
         if (crc_clr)
            rx_crc_q <= 16'h0000;
         else if (rx_crc_shift)
            rx_crc_q <= {rx_crc_q[14:0], iData_pin};
      end
   end

   assign crc_val   = crc_q;
   assign crc_match = (rx_crc_q == crc_q);
`else
   logic crc_unused;
   assign crc_unused = ^{crc_clr, crc_in_valid, crc_in_bit, crc_tx_shift, rx_crc_shift};
   assign crc_val    = 16'h0000;
   assign crc_match  = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      wbit_d       = wbit_q;
      word_d       = word_q;
      ph_d         = ph_q;
      sr_d         = sr_q;
      we_d         = 1'b0;
      wdata_d      = wdata_q;
      done_d       = 1'b0;
      crc_err_d    = crc_err_q;
      pin_c        = 1'b1;
      oe_c         = 1'b0;
      rd_en_c      = 1'b0;
      crc_clr      = 1'b0;
      crc_in_valid = 1'b0;
      crc_in_bit   = 1'b0;
      crc_tx_shift = 1'b0;
      rx_crc_shift = 1'b0;

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            wbit_d    = '0;
            word_d    = '0;
            ph_d      = '0;
            crc_clr   = 1'b1;
            if (iWrite_start) begin
               state_d   = RX_WAIT;
               crc_err_d = 1'b0;
            end else if (iRead_start) begin
               state_d = TX_WAIT;
            end
         end
         RX_WAIT: begin
            if (!iData_pin)
               state_d = RX_DATA;
         end
         RX_DATA: begin
            sr_d         = {sr_q[WORD_SIZE-2:0], iData_pin};
            crc_in_valid = 1'b1;
            crc_in_bit   = iData_pin;
            bit_cnt_d    = bit_cnt_q + BIT_W'(1);
            if (wbit_q == WBIT_W'(WORD_SIZE - 1)) begin
               we_d    = 1'b1;
               wdata_d = {sr_q[WORD_SIZE-2:0], iData_pin};
               wbit_d  = '0;
               word_d  = word_q + WORD_W'(1);
            end else begin
               wbit_d = wbit_q + WBIT_W'(1);
            end
            if (bit_cnt_q == BIT_W'(BLOCK_BITS - 1)) begin
               state_d = RX_CRC;
               ph_d    = '0;
            end
         end
         RX_CRC: begin
            rx_crc_shift = 1'b1;
            ph_d         = ph_q + PH_W'(1);
            if (ph_q == PH_W'(15)) begin
               state_d = RX_END;
               ph_d    = '0;
            end
         end
         RX_END: begin
            crc_err_d = !iData_pin || !crc_match;
            state_d   = TOK_GAP;
            ph_d      = '0;
         end
         TOK_GAP: begin
            oe_c = 1'b1;
            ph_d = ph_q + PH_W'(1);
            if (ph_q == PH_W'(1)) begin
               state_d = TOK;
               ph_d    = '0;
            end
         end
         TOK: begin
            // token: start 0, status 010 (ok) / 101 (error), end 1
            oe_c = 1'b1;
            case (ph_q)
               PH_W'(0): pin_c = 1'b0;
               PH_W'(1): pin_c = crc_err_q;
               PH_W'(2): pin_c = !crc_err_q;
               PH_W'(3): pin_c = crc_err_q;
               default:  pin_c = 1'b1;
            endcase
            ph_d = ph_q + PH_W'(1);
            if (ph_q == PH_W'(4)) begin
               state_d = BUSY;
               ph_d    = '0;
            end
         end
         BUSY: begin
            // BUSY_CYCLES low cycles, then one release cycle high with oBlock_done
            oe_c  = 1'b1;
            pin_c = (ph_q == PH_W'(BUSY_CYCLES));
            if (ph_q == PH_W'(BUSY_CYCLES - 1))
               done_d = 1'b1;
            if (ph_q == PH_W'(BUSY_CYCLES)) begin
               state_d = IDLE;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         TX_WAIT: begin
            rd_en_c = (ph_q == '0);
            if (ph_q == PH_W'(NAC - 1)) begin
               oe_c    = 1'b1;
               pin_c   = 1'b0;
               state_d = TX_DATA;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PH_W'(1);
            end
         end
         TX_DATA: begin
            oe_c         = 1'b1;
            pin_c        = sr_q[WORD_SIZE-1];
            sr_d         = {sr_q[WORD_SIZE-2:0], 1'b0};
            crc_in_valid = 1'b1;
            crc_in_bit   = sr_q[WORD_SIZE-1];
            bit_cnt_d    = bit_cnt_q + BIT_W'(1);
            // Next word is requested while bit 1 is on the pin so it lands
            // on the edge that ends bit 0.
            rd_en_c = (wbit_q == WBIT_W'(WORD_SIZE - 2)) &&
                      (word_q != WORD_W'(WORDS_PER_BLOCK - 1));
            if (wbit_q == WBIT_W'(WORD_SIZE - 1)) begin
               wbit_d = '0;
               word_d = word_q + WORD_W'(1);
            end else begin
               wbit_d = wbit_q + WBIT_W'(1);
            end
            if (bit_cnt_q == BIT_W'(BLOCK_BITS - 1)) begin
               state_d = TX_CRC;
               ph_d    = '0;
            end
         end
         TX_CRC: begin
            oe_c         = 1'b1;
            pin_c        = crc_val[15];
            crc_tx_shift = 1'b1;
            ph_d         = ph_q + PH_W'(1);
            if (ph_q == PH_W'(15)) begin
               state_d = TX_END;
               ph_d    = '0;
            end
         end
         TX_END: begin
            oe_c    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // The fetched word replaces the shifted value on the edge it arrives.
      if (ld_q)
         sr_d = iData_from_buffer;
      ld_d = rd_en_c;

      if (iAbort) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         wbit_d    = '0;
         word_d    = '0;
         ph_d      = '0;
         ld_d      = 1'b0;
         we_d      = 1'b0;
         done_d    = 1'b0;
         crc_err_d = crc_err_q;
         crc_clr   = 1'b1;
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         wbit_q    <= '0;
         word_q    <= '0;
         ph_q      <= '0;
         sr_q      <= '0;
         ld_q      <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         done_q    <= 1'b0;
         crc_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         wbit_q    <= wbit_d;
         word_q    <= word_d;
         ph_q      <= ph_d;
         sr_q      <= sr_d;
         ld_q      <= ld_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         crc_err_q <= crc_err_d;
      end
   end

   assign oData_pin       = pin_c;
   assign oData_oe        = oe_c;
   assign oRead_enable    = rd_en_c;
   assign oData_to_buffer = wdata_q;
   assign oWrite_enable   = we_q;
   assign oBlock_done     = done_q;
   assign oCrc_error      = crc_err_q;

endmodule

// File: tb/tb_sd_card_data_responder.sv
// Directed bench for sd_card_data_responder with WORDS_PER_BLOCK=2.
// Expected values follow the DAT0 framing; CRC16 reference values come from
// an augmented-message polynomial division independent of the DUT datapath.
module tb_sd_card_data_responder;

`ifdef SD_CARD_CRC_EN
   localparam bit CRC_ON = 1'b1;
`else
   localparam bit CRC_ON = 1'b0;
`endif

   logic        iClock = 1'b0;
   logic        iReset = 1'b0;
   logic        iData_pin = 1'b1;
   logic        oData_pin, oData_oe;
   logic        iWrite_start = 1'b0, iRead_start = 1'b0, iAbort = 1'b0;
   logic [31:0] iData_from_buffer = 32'h0;
   logic        oRead_enable;
   logic [31:0] oData_to_buffer;
   logic        oWrite_enable, oBlock_done, oCrc_error;

   int checks = 0;
   int failures = 0;

   sd_card_data_responder #(
      .WORD_SIZE(32), .WORDS_PER_BLOCK(2), .NAC(2), .BUSY_CYCLES(8)
   ) dut (
      .iClock(iClock), .iReset(iReset), .iData_pin(iData_pin),
      .oData_pin(oData_pin), .oData_oe(oData_oe),
      .iWrite_start(iWrite_start), .iRead_start(iRead_start), .iAbort(iAbort),
      .iData_from_buffer(iData_from_buffer), .oRead_enable(oRead_enable),
      .oData_to_buffer(oData_to_buffer), .oWrite_enable(oWrite_enable),
      .oBlock_done(oBlock_done), .oCrc_error(oCrc_error)
   );

   always #5 iClock = ~iClock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   // remainder of msg*x^16 mod (x^16+x^12+x^5+1)
   function automatic logic [15:0] crc_model(input logic [63:0] msg);
      logic [15:0] r;
      logic [79:0] m;
      logic        top;
      r = 16'h0;
      m = {msg, 16'h0};
      for (int i = 79; i >= 0; i--) begin
         top = r[15];
         r = {r[14:0], m[i]};
         if (top) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   task automatic host_write(input logic do_start, input logic [63:0] blk,
                             input logic [15:0] crc, input logic endbit,
                             input int abort_at, input logic exp_err,
                             input string name);
      logic [15:0] pvec, dvec, exp_pvec;
      logic        oe_all, late_done;
      int          we_cnt;
      we_cnt = 0;
      if (do_start) begin
         iWrite_start = 1'b1;
         tick();
         iWrite_start = 1'b0;
      end
      check({name, "_err_cleared"}, oCrc_error, 1'b0);
      check({name, "_rxwait_oe"}, oData_oe, 1'b0);
      iData_pin = 1'b0;
      tick();
      for (int i = 0; i < 64; i++) begin
         iData_pin = blk[63-i];
         tick();
         if (oWrite_enable) we_cnt++;
         if (i == 31) check({name, "_word0"}, {oWrite_enable, oData_to_buffer}, {1'b1, blk[63:32]});
         if (i == 63) check({name, "_word1"}, {oWrite_enable, oData_to_buffer}, {1'b1, blk[31:0]});
      end
      for (int i = 0; i < 16; i++) begin
         iData_pin = crc[15-i];
         tick();
         if (oWrite_enable) we_cnt++;
      end
      iData_pin = endbit;
      tick();
      iData_pin = 1'b1;
      check({name, "_we_pulses"}, we_cnt, 2);
      exp_pvec = exp_err ? 16'hD601 : 16'hCA01;
      pvec = '0; dvec = '0; oe_all = 1'b1;
      for (int k = 0; k < 16; k++) begin
         pvec = {pvec[14:0], oData_pin};
         dvec = {dvec[14:0], oBlock_done};
         oe_all = oe_all & oData_oe;
         if (k == abort_at) begin
            check({name, "_pre_abort_pins"}, pvec, exp_pvec >> (15 - k));
            iAbort = 1'b1;
            tick();
            iAbort = 1'b0;
            check({name, "_abort_oe_done"}, {oData_oe, oBlock_done}, 2'b00);
            late_done = 1'b0;
            for (int j = 0; j < 4; j++) begin
               tick();
               late_done = late_done | oBlock_done | oData_oe;
            end
            check({name, "_abort_quiet"}, late_done, 1'b0);
            check({name, "_abort_err_kept"}, oCrc_error, exp_err);
            $display("TXN %s aborted in busy", name);
            return;
         end
         tick();
      end
      check({name, "_token_busy_pins"}, pvec, exp_pvec);
      check({name, "_oe_held"}, oe_all, 1'b1);
      check({name, "_done_pos"}, dvec, 16'h0001);
      check({name, "_idle_after"}, {oData_oe, oBlock_done}, 2'b00);
      check({name, "_crc_err"}, oCrc_error, exp_err);
      $display("TXN %s write blk=%h crc=%h end=%0b err=%0b", name, blk, crc, endbit, oCrc_error);
   endtask

   task automatic host_read(input logic [31:0] w0, input logic [31:0] w1);
      logic [31:0] words [2];
      logic [63:0] obs_data;
      logic [15:0] obs_crc, exp_crc;
      logic        prev_re, oe_all, early_done;
      int          idx, re_cnt, re_first, re_second;
      words[0] = w0; words[1] = w1;
      exp_crc = CRC_ON ? crc_model({w0, w1}) : 16'h0000;
      idx = 0; re_cnt = 0; re_first = -1; re_second = -1;
      prev_re = 1'b0; oe_all = 1'b1; early_done = 1'b0;
      obs_data = '0; obs_crc = '0;
      iRead_start = 1'b1;
      tick();
      iRead_start = 1'b0;
      for (int n = 1; n <= 84; n++) begin
         if (prev_re && idx < 2) begin
            iData_from_buffer = words[idx];
            idx++;
         end
         prev_re = oRead_enable;
         if (oRead_enable) begin
            re_cnt++;
            if (re_first < 0) re_first = n;
            else if (re_second < 0) re_second = n;
         end
         if (n == 1) check("rd_wait_oe", {oData_oe, oData_pin}, 2'b01);
         if (n == 2) check("rd_start_bit", {oData_oe, oData_pin}, 2'b10);
         if (n >= 3 && n <= 66) obs_data = {obs_data[62:0], oData_pin};
         if (n >= 67 && n <= 82) obs_crc = {obs_crc[14:0], oData_pin};
         if (n >= 2 && n <= 83) oe_all = oe_all & oData_oe;
         if (n < 84) early_done = early_done | oBlock_done;
         if (n == 83) check("rd_end_bit", oData_pin, 1'b1);
         if (n == 84) check("rd_release_done", {oData_oe, oBlock_done}, 2'b01);
         if (n < 84) tick();
      end
      check("rd_data", obs_data, {w0, w1});
      check("rd_crc", obs_crc, exp_crc);
      check("rd_oe_held", oe_all, 1'b1);
      check("rd_no_early_done", early_done, 1'b0);
      check("rd_re_count", re_cnt, 2);
      check("rd_re_timing", {re_first[15:0], re_second[15:0]}, {16'd1, 16'd33});
      $display("TXN read data=%h crc=%h re=%0d", obs_data, obs_crc, re_cnt);
   endtask

   initial begin : main
      logic [63:0] blk_a;
      logic [15:0] crc_a;
      logic        both_bad;
      blk_a = {32'hDEADBEEF, 32'h01234567};
      crc_a = crc_model(blk_a);

      #2;
      check("reset_outputs",
            {oData_pin, oData_oe, oRead_enable, oWrite_enable, oBlock_done, oCrc_error},
            6'b100000);
      check("reset_wdata", oData_to_buffer, 32'h0);
      #10 iReset = 1'b1;
      tick();
      $display("TXN reset released");

      host_write(1'b1, blk_a, crc_a, 1'b1, -1, 1'b0, "wr_ok");
      host_write(1'b1, blk_a ^ 64'h0000_0100_0000_0000, crc_a, 1'b1, -1, CRC_ON, "wr_flip");
      host_write(1'b1, blk_a, crc_a, 1'b0, -1, 1'b1, "wr_endbit0");

      tick();
      host_read(32'hA5A5A5A5, 32'h0000FFFF);
      check("rd_err_sticky", oCrc_error, 1'b1);
      tick();

      // simultaneous starts: write wins, card stays off the line
      iRead_start = 1'b1; iWrite_start = 1'b1;
      tick();
      iRead_start = 1'b0; iWrite_start = 1'b0;
      both_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         both_bad = both_bad | oData_oe | oRead_enable;
         tick();
      end
      check("both_start_quiet", both_bad, 1'b0);
      host_write(1'b0, blk_a, crc_a, 1'b1, -1, 1'b0, "wr_after_both");

      // reset in the middle of the data phase
      iWrite_start = 1'b1;
      tick();
      iWrite_start = 1'b0;
      iData_pin = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         iData_pin = blk_a[63-i];
         tick();
      end
      #2 iReset = 1'b0;
      #1;
      check("midrst_outputs",
            {oData_pin, oData_oe, oRead_enable, oWrite_enable, oBlock_done},
            5'b10000);
      check("midrst_wdata", oData_to_buffer, 32'h0);
      iData_pin = 1'b1;
      @(negedge iClock);
      iReset = 1'b1;
      tick();
      $display("TXN reset during rx data");
      host_write(1'b1, blk_a, crc_a, 1'b1, -1, 1'b0, "wr_post_rst");

      host_write(1'b1, blk_a, crc_a, 1'b0, 10, 1'b1, "wr_abort");
      host_write(1'b1, blk_a, crc_a, 1'b1, -1, 1'b0, "wr_post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
